sram_pp_sched: RTL and testbench
================================

SRAM_PP_SCHED -- requirements
Module: sram_pp_sched

Interface
REQ-001 Parameters: AW, 10, SRAM address width; DW, 24, SRAM data width.
REQ-002 The block SHALL have the following ports.
- clk_100m  in  1  sole clock; all logic on rising edge.
- rst_sram  in  1  reset; synchronous, active-high.
- cpuif_mode  in  1  1 = CPU test access only; packet ports blocked.
- wr_req / wr_addr / wr_data  in  1/AW/DW  writer word-write request.
- wr_done  in  1  pulse; writer closes the current write bank.
- wr_gnt  out  1  write accepted this cycle.
- rd_req / rd_addr  in  1/AW  reader word-read request.
- rd_done  in  1  pulse; reader releases the current read bank.
- rd_gnt  out  1  read accepted this cycle.
- rd_data / rd_vld  out  DW/1  read return.
- cpu_req / cpu_we / cpu_bank / cpu_addr / cpu_wdata  in  1/1/1/AW/DW  CPU access; cpu_bank 0 = A, 1 = B.
- cpu_gnt  out  1  CPU access accepted.
- cpu_rdata / cpu_rvld  out  DW/1  CPU read return.
- wr_bank / rd_bank  out  1/1  current write/read bank.
- bank_full  out  2  bit0 = A FULL, bit1 = B FULL.
- SRAM_CS_A_N / SRAM_WE_A_N / SRAM_ADDR_A / SRAM_WDATA_A  out  1/1/AW/DW  bank A command.
- SRAM_RDATA_A  in  DW  bank A read data, one cycle after a registered read command.
- SRAM_CS_B_N / SRAM_WE_B_N / SRAM_ADDR_B / SRAM_WDATA_B / SRAM_RDATA_B  as for bank A.

Function
REQ-003 Each bank SHALL hold one state: EMPTY, FILLING, FULL or DRAINING.
REQ-004 Writer eligibility: cpuif_mode = 0 and bank wr_bank in EMPTY or FILLING; wr_gnt = wr_req & eligible, combinational.
REQ-005 A granted write SHALL move the bank EMPTY -> FILLING.
REQ-006 wr_done on a FILLING bank SHALL set it FULL and toggle wr_bank; wr_done on an EMPTY bank SHALL be ignored.
REQ-007 wr_req and wr_done in the same cycle: the write completes first, then the bank closes (EMPTY -> FULL directly allowed).
REQ-008 Reader eligibility: cpuif_mode = 0 and bank rd_bank in FULL or DRAINING; rd_gnt = rd_req & eligible, combinational.
REQ-009 A granted read SHALL move the bank FULL -> DRAINING.
REQ-010 rd_done on a FULL or DRAINING bank SHALL set it EMPTY and toggle rd_bank; otherwise rd_done is ignored.
REQ-011 wr_done and rd_done in the same cycle SHALL both take effect; writer and reader never target the same bank.
REQ-012 Writer with both banks FULL/DRAINING: wr_gnt stays 0 (stall) and no data is dropped.
REQ-013 CPU arbitration, cpuif_mode = 1: cpu_gnt = cpu_req; bank states are frozen.
REQ-014 CPU arbitration, cpuif_mode = 0: cpu_gnt = cpu_req only if no packet grant targets cpu_bank that cycle; packet ports have priority.
REQ-015 Each bank SHALL receive at most one command per cycle.
REQ-016 SRAM command outputs SHALL be registered: a grant in cycle N drives CS_N = 0 (WE_N = 0 for writes), ADDR and WDATA in cycle N+1.
REQ-017 Idle banks SHALL drive CS_N = 1, WE_N = 1, and hold ADDR/WDATA.
REQ-018 Read latency: a read granted in cycle N SHALL return registered data with rd_vld (or cpu_rvld) high in cycle N+3, for exactly one cycle.
REQ-019 Return routing SHALL follow a 2-stage pipeline tag (requester, bank), unaffected by later bank toggles or cpuif_mode changes.
REQ-020 Back-to-back reads SHALL sustain one return per cycle.
REQ-021 bank_full[i] = 1 iff bank i is FULL.

Reset
REQ-022 rst_sram = 1 at a clock edge SHALL set:
- both banks EMPTY; wr_bank = 0; rd_bank = 0;
- all CS_N and WE_N = 1; SRAM_ADDR_x = 0; SRAM_WDATA_x = 0;
- rd_vld = 0, cpu_rvld = 0, rd_data = 0, cpu_rdata = 0; pipeline tags cleared.
REQ-023 During reset all grants SHALL be 0.
REQ-024 Reset mid-operation SHALL discard in-flight reads with no late rd_vld or cpu_rvld.

Verification
REQ-025 Ping-pong: write 4 words to A, wr_done -> wr_bank = 1, bank_full = 01; read A from addresses 0-3 -> data returned in order, each 3 cycles after its grant; rd_done -> A EMPTY.
REQ-026 Stall: fill A and B, both closed -> wr_gnt = 0 while wr_req = 1; rd_done on A -> wr_gnt = 1 the next cycle, and the write goes to A.
REQ-027 Conflict: writer to A and CPU to A (cpuif_mode = 0) in the same cycle -> wr_gnt = 1, cpu_gnt = 0; CPU to B the same cycle -> cpu_gnt = 1.
REQ-028 Test mode: cpuif_mode = 1; CPU writes 24'hA5A5A5 to B addr 10'h3FF, then reads it -> cpu_rvld with 24'hA5A5A5; wr_gnt = rd_gnt = 0 throughout.
REQ-029 Simultaneous/edge events: wr_done + rd_done in the same cycle -> both banks transition and both pointers toggle; wr_done on an EMPTY bank -> no change.
REQ-030 Reset: rst_sram = 1 one cycle after a read grant -> no rd_vld afterwards; all outputs at their reset values.

Source files
------------

// File: rtl/sram_pp_sched.sv
// sram_pp_sched: ping-pong scheduler for two single-port SRAM banks shared by a packet writer,
// a packet reader and a CPU test port, with registered commands and tagged 3-cycle read returns.
module sram_pp_sched #(
   parameter int AW = 10,
   parameter int DW = 24
) (
   input  logic          clk_100m,
   input  logic          rst_sram,
   input  logic          cpuif_mode,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_done,
   output logic          wr_gnt,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_done,
   output logic          rd_gnt,
   output logic [DW-1:0] rd_data,
   output logic          rd_vld,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic          cpu_bank,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvld,
   output logic          wr_bank,
   output logic          rd_bank,
   output logic [1:0]    bank_full,
   output logic          SRAM_CS_A_N,
   output logic          SRAM_WE_A_N,
   output logic [AW-1:0] SRAM_ADDR_A,
   output logic [DW-1:0] SRAM_WDATA_A,
   input  logic [DW-1:0] SRAM_RDATA_A,
   output logic          SRAM_CS_B_N,
   output logic          SRAM_WE_B_N,
   output logic [AW-1:0] SRAM_ADDR_B,
   output logic [DW-1:0] SRAM_WDATA_B,
   input  logic [DW-1:0] SRAM_RDATA_B
);
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;
   bank_st_e           st_q [2];
   bank_st_e           st_d [2];
   logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0]         cs_n_q, cs_n_d, we_n_q, we_n_d;
   logic [1:0][AW-1:0] addr_q, addr_d;
   logic [1:0][DW-1:0] wdata_q, wdata_d;
   logic [1:0]         rd_tv_q, rd_tv_d, rd_tb_q, rd_tb_d;
   logic [1:0]         cp_tv_q, cp_tv_d, cp_tb_q, cp_tb_d;
   logic               rd_vld_q, rd_vld_d, cpu_rvld_q, cpu_rvld_d;
   logic [DW-1:0]      rd_data_q, rd_data_d, cpu_rdata_q, cpu_rdata_d;
   logic               wr_elig, rd_elig, wr_close, rd_close;

   always_comb begin
      wr_elig   = !rst_sram && !cpuif_mode && (st_q[wr_bank_q] == EMPTY || st_q[wr_bank_q] == FILLING);
      rd_elig   = !rst_sram && !cpuif_mode && (st_q[rd_bank_q] == FULL || st_q[rd_bank_q] == DRAINING);
      wr_gnt    = wr_req && wr_elig;
      rd_gnt    = rd_req && rd_elig;
      cpu_gnt   = !rst_sram && cpu_req && (cpuif_mode ||
                  (!(wr_gnt && wr_bank_q == cpu_bank) && !(rd_gnt && rd_bank_q == cpu_bank)));
      // a write granted together with wr_done lands first, so an EMPTY bank may close straight to FULL
      wr_close  = !cpuif_mode && wr_done && (st_q[wr_bank_q] == FILLING || wr_gnt);
      rd_close  = !cpuif_mode && rd_done && (st_q[rd_bank_q] == FULL || st_q[rd_bank_q] == DRAINING);
      wr_bank_d = wr_bank_q ^ wr_close;
      rd_bank_d = rd_bank_q ^ rd_close;
      for (int i = 0; i < 2; i++) begin
         st_d[i]    = st_q[i];
         cs_n_d[i]  = 1'b1;
         we_n_d[i]  = 1'b1;
         addr_d[i]  = addr_q[i];
         wdata_d[i] = wdata_q[i];
         if (wr_gnt && wr_bank_q == 1'(i)) begin
            cs_n_d[i]  = 1'b0;
            we_n_d[i]  = 1'b0;
            addr_d[i]  = wr_addr;
            wdata_d[i] = wr_data;
            st_d[i]    = st_q[i] == EMPTY ? FILLING : st_q[i];
         end
         if (rd_gnt && rd_bank_q == 1'(i)) begin
            cs_n_d[i] = 1'b0;
            addr_d[i] = rd_addr;
            st_d[i]   = st_q[i] == FULL ? DRAINING : st_q[i];
         end
         if (cpu_gnt && cpu_bank == 1'(i)) begin
            cs_n_d[i]  = 1'b0;
            we_n_d[i]  = !cpu_we;
            addr_d[i]  = cpu_addr;
            wdata_d[i] = cpu_we ? cpu_wdata : wdata_q[i];
         end
         if (wr_close && wr_bank_q == 1'(i))
            st_d[i] = FULL;
         if (rd_close && rd_bank_q == 1'(i))
            st_d[i] = EMPTY;
      end
      // per-requester tags ride alongside the command and SRAM data so returns ignore later toggles
      rd_tv_d     = {rd_tv_q[0], rd_gnt};
      rd_tb_d     = {rd_tb_q[0], rd_bank_q};
      cp_tv_d     = {cp_tv_q[0], cpu_gnt && !cpu_we};
      cp_tb_d     = {cp_tb_q[0], cpu_bank};
      rd_vld_d    = rd_tv_q[1];
      cpu_rvld_d  = cp_tv_q[1];
      rd_data_d   = rd_tv_q[1] ? (rd_tb_q[1] ? SRAM_RDATA_B : SRAM_RDATA_A) : rd_data_q;
      cpu_rdata_d = cp_tv_q[1] ? (cp_tb_q[1] ? SRAM_RDATA_B : SRAM_RDATA_A) : cpu_rdata_q;
   end

   always_ff @(posedge clk_100m) begin
      if (rst_sram) begin
         st_q[0]     <= EMPTY;
         st_q[1]     <= EMPTY;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         cs_n_q      <= 2'b11;
         we_n_q      <= 2'b11;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_tv_q     <= '0;
         rd_tb_q     <= '0;
         cp_tv_q     <= '0;
         cp_tb_q     <= '0;
         rd_vld_q    <= 1'b0;
         cpu_rvld_q  <= 1'b0;
         rd_data_q   <= '0;
         cpu_rdata_q <= '0;
      end else begin
         st_q        <= st_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         cs_n_q      <= cs_n_d;
         we_n_q      <= we_n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_tv_q     <= rd_tv_d;
         rd_tb_q     <= rd_tb_d;
         cp_tv_q     <= cp_tv_d;
         cp_tb_q     <= cp_tb_d;
         rd_vld_q    <= rd_vld_d;
         cpu_rvld_q  <= cpu_rvld_d;
         rd_data_q   <= rd_data_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign wr_bank      = wr_bank_q;
   assign rd_bank      = rd_bank_q;
   assign bank_full    = {st_q[1] == FULL, st_q[0] == FULL};
   assign rd_vld       = rd_vld_q;
   assign rd_data      = rd_data_q;
   assign cpu_rvld     = cpu_rvld_q;
   assign cpu_rdata    = cpu_rdata_q;
   assign SRAM_CS_A_N  = cs_n_q[0];
   assign SRAM_WE_A_N  = we_n_q[0];
   assign SRAM_ADDR_A  = addr_q[0];
   assign SRAM_WDATA_A = wdata_q[0];
   assign SRAM_CS_B_N  = cs_n_q[1];
   assign SRAM_WE_B_N  = we_n_q[1];
   assign SRAM_ADDR_B  = addr_q[1];
   assign SRAM_WDATA_B = wdata_q[1];
endmodule

// File: tb/tb_sram_pp_sched.sv
// tb_sram_pp_sched: table-driven per-cycle vectors against a behavioural two-bank SRAM,
// plus hand sequences for reset behaviour and an in-flight read cut by reset.
module tb_sram_pp_sched;
   localparam int AW = 10;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpuif_mode, wr_req, wr_done, rd_req, rd_done, cpu_req, cpu_we, cpu_bank;
   logic [AW-1:0] wr_addr, rd_addr, cpu_addr;
   logic [DW-1:0] wr_data, cpu_wdata;
   logic          wr_gnt, rd_gnt, cpu_gnt, rd_vld, cpu_rvld, wr_bank, rd_bank;
   logic [DW-1:0] rd_data, cpu_rdata;
   logic [1:0]    bank_full;
   logic          cs_a_n, we_a_n, cs_b_n, we_b_n;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic [DW-1:0] rdata_a = '0;
   logic [DW-1:0] rdata_b = '0;
   logic [DW-1:0] mem_a [1024];
   logic [DW-1:0] mem_b [1024];

   always #5 clk = ~clk;

   sram_pp_sched #(.AW(AW), .DW(DW)) dut (
      .clk_100m(clk), .rst_sram(rst), .cpuif_mode(cpuif_mode),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_vld(rd_vld),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvld(cpu_rvld),
      .wr_bank(wr_bank), .rd_bank(rd_bank), .bank_full(bank_full),
      .SRAM_CS_A_N(cs_a_n), .SRAM_WE_A_N(we_a_n), .SRAM_ADDR_A(addr_a),
      .SRAM_WDATA_A(wdata_a), .SRAM_RDATA_A(rdata_a),
      .SRAM_CS_B_N(cs_b_n), .SRAM_WE_B_N(we_b_n), .SRAM_ADDR_B(addr_b),
      .SRAM_WDATA_B(wdata_b), .SRAM_RDATA_B(rdata_b)
   );

   always @(posedge clk) begin
      if (!cs_a_n) begin
         if (!we_a_n) mem_a[addr_a] <= wdata_a;
         else rdata_a <= mem_a[addr_a];
      end
      if (!cs_b_n) begin
         if (!we_b_n) mem_b[addr_b] <= wdata_b;
         else rdata_b <= mem_b[addr_b];
      end
   end

   typedef struct {
      int mode, wr, wa, wd, wdn;
      int rr, ra, rdn;
      int cr, cwe, cb, ca, cd;
      int wg, rg, cg;
      int wb, rb, bf;
      int rv, rdat;
      int cv, cdat;
   } vec_t;

   vec_t vt [23];
   vec_t idle;
   int   n_run = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cpuif_mode = 1'(v.mode);
      wr_req     = 1'(v.wr);
      wr_addr    = AW'(v.wa);
      wr_data    = DW'(v.wd);
      wr_done    = 1'(v.wdn);
      rd_req     = 1'(v.rr);
      rd_addr    = AW'(v.ra);
      rd_done    = 1'(v.rdn);
      cpu_req    = 1'(v.cr);
      cpu_we     = 1'(v.cwe);
      cpu_bank   = 1'(v.cb);
      cpu_addr   = AW'(v.ca);
      cpu_wdata  = DW'(v.cd);
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, " cs_a_n"}, cs_a_n, 1);
      chk({nm, " we_a_n"}, we_a_n, 1);
      chk({nm, " addr_a"}, addr_a, 0);
      chk({nm, " wdata_a"}, wdata_a, 0);
      chk({nm, " cs_b_n"}, cs_b_n, 1);
      chk({nm, " we_b_n"}, we_b_n, 1);
      chk({nm, " addr_b"}, addr_b, 0);
      chk({nm, " wdata_b"}, wdata_b, 0);
      chk({nm, " rd_vld"}, rd_vld, 0);
      chk({nm, " cpu_rvld"}, cpu_rvld, 0);
      chk({nm, " rd_data"}, rd_data, 0);
      chk({nm, " cpu_rdata"}, cpu_rdata, 0);
      chk({nm, " wr_bank"}, wr_bank, 0);
      chk({nm, " rd_bank"}, rd_bank, 0);
      chk({nm, " bank_full"}, bank_full, 0);
   endtask

   initial begin
      idle = '{default: 0};
      vt = '{
         '{0,1,0,'h100,0,   0,0,0, 1,1,0,5,'h55,         1,0,0, 0,0,0, 0,0,     0,0},
         '{0,1,1,'h101,0,   0,0,0, 1,1,1,9,'h99,         1,0,1, 0,0,0, 0,0,     0,0},
         '{0,1,2,'h102,0,   1,0,0, 0,0,0,0,0,            1,0,0, 0,0,0, 0,0,     0,0},
         '{0,1,3,'h103,1,   0,0,0, 0,0,0,0,0,            1,0,0, 1,0,1, 0,0,     0,0},
         '{0,1,0,'h200,0,   1,0,0, 1,1,0,5,'h55,         1,1,0, 1,0,0, 0,0,     0,0},
         '{0,0,0,0,0,       1,1,0, 1,1,1,9,'h99,         0,1,1, 1,0,0, 0,0,     0,0},
         '{0,0,0,0,0,       1,2,0, 0,0,0,0,0,            0,1,0, 1,0,0, 1,'h100, 0,0},
         '{0,0,0,0,0,       1,3,0, 0,0,0,0,0,            0,1,0, 1,0,0, 1,'h101, 0,0},
         '{0,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,0, 1,'h102, 0,0},
         '{0,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,0, 1,'h103, 0,0},
         '{0,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,0, 0,'h103, 0,0},
         '{0,0,0,0,1,       0,0,1, 0,0,0,0,0,            0,0,0, 0,1,2, 0,'h103, 0,0},
         '{0,0,0,0,1,       0,0,0, 0,0,0,0,0,            0,0,0, 0,1,2, 0,'h103, 0,0},
         '{0,1,0,'h300,1,   0,0,0, 0,0,0,0,0,            1,0,0, 1,1,3, 0,'h103, 0,0},
         '{0,1,7,'h777,0,   0,0,0, 0,0,0,0,0,            0,0,0, 1,1,3, 0,'h103, 0,0},
         '{0,1,7,'h777,0,   0,0,1, 0,0,0,0,0,            0,0,0, 1,0,1, 0,'h103, 0,0},
         '{0,1,7,'h777,0,   0,0,0, 0,0,0,0,0,            1,0,0, 1,0,1, 0,'h103, 0,0},
         '{1,1,7,'h777,0,   1,0,0, 1,1,1,'h3FF,'hA5A5A5, 0,0,1, 1,0,1, 0,'h103, 0,0},
         '{1,1,7,'h777,1,   1,0,1, 1,0,1,'h3FF,0,        0,0,1, 1,0,1, 0,'h103, 0,0},
         '{1,0,0,0,0,       0,0,0, 1,0,1,7,0,            0,0,1, 1,0,1, 0,'h103, 0,0},
         '{1,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,1, 0,'h103, 1,'hA5A5A5},
         '{0,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,1, 0,'h103, 1,'h777},
         '{0,0,0,0,0,       0,0,0, 0,0,0,0,0,            0,0,0, 1,0,1, 0,'h103, 0,'h777}
      };
      drive(idle);
      rst = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;
      cpu_req = 1'b1;
      @(negedge clk);
      #1;
      chk("rst wr_gnt", wr_gnt, 0);
      chk("rst rd_gnt", rd_gnt, 0);
      chk("rst cpu_gnt mode0", cpu_gnt, 0);
      cpuif_mode = 1'b1;
      #1;
      chk("rst cpu_gnt mode1", cpu_gnt, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_rst("reset");
      @(negedge clk);
      rst = 1'b0;
      drive(idle);
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         chk($sformatf("v%0d wr_gnt", i), wr_gnt, vt[i].wg);
         chk($sformatf("v%0d rd_gnt", i), rd_gnt, vt[i].rg);
         chk($sformatf("v%0d cpu_gnt", i), cpu_gnt, vt[i].cg);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wr_bank", i), wr_bank, vt[i].wb);
         chk($sformatf("v%0d rd_bank", i), rd_bank, vt[i].rb);
         chk($sformatf("v%0d bank_full", i), bank_full, vt[i].bf);
         chk($sformatf("v%0d rd_vld", i), rd_vld, vt[i].rv);
         chk($sformatf("v%0d rd_data", i), rd_data, vt[i].rdat);
         chk($sformatf("v%0d cpu_rvld", i), cpu_rvld, vt[i].cv);
         chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].cdat);
      end
      // bank A is FULL and rd_bank = 0 here: grant a read, then reset before it returns
      @(negedge clk);
      drive(idle);
      rd_req = 1'b1;
      rd_addr = 10'h2A;
      #1;
      chk("flight rd_gnt", rd_gnt, 1);
      @(posedge clk);
      #1;
      chk("flight cs_a_n", cs_a_n, 0);
      chk("flight we_a_n", we_a_n, 1);
      chk("flight addr_a", addr_a, 10'h2A);
      chk("flight cs_b_n", cs_b_n, 1);
      @(negedge clk);
      rd_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("flight rst rd_gnt", rd_gnt, 0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("flight late rd_vld c%0d", k), rd_vld, 0);
         chk($sformatf("flight late cpu_rvld c%0d", k), cpu_rvld, 0);
         if (k == 0) rst = 1'b0;
      end
      chk_rst("post reset");
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
